// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Pending-write tracker for the ID stage of the 16-bit pipelined TSC core.
// Each architectural register has a small counter of in-flight writes
// (issued past ID, not yet written back by WB). A decoding instruction
// stalls when a source register still has a write outstanding that the WB
// write-through cannot cover this cycle. It also stalls when its destination
// already has the maximum number of in-flight writes.
//
// Ports
//   clk            clock
//   reset_n        asynchronous reset, ACTIVE-HIGH (the name is historical)
//   issue_valid    ID has an instruction requesting issue
//   issue_we       issuing instruction writes a register
//   issue_dest     destination register of the issuing instruction
//   src1_used/addr rs read enable / address
//   src2_used/addr rt read enable / address
//   retire_valid   WB register-file write enable
//   retire_dest    WB register-file write address
//   stall          ID must hold (combinational)
//   issue_accept   issue_valid & ~stall (combinational)
//   pending        bit i set while register i has an outstanding write
//   inflight       total outstanding writes over all registers
//   err_underflow  sticky: retire seen for a register with nothing pending
//   err_overflow   sticky: increment attempted on a full counter
// ---------------------------------------------------------------------------

// Per-register pending counter. This is one lane of the scoreboard.
module reg_sb_cnt #(
    parameter int CNT_W    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,      // accepted write issued to this reg
    input  logic             dec_req_i,  // WB writes this reg this cycle
    output logic [CNT_W-1:0] cnt_o,
    output logic             inc_eff_o,  // increment actually applied
    output logic             dec_eff_o,  // decrement actually applied
    output logic             ovf_o,      // increment dropped at saturation
    output logic             unf_o       // retire with nothing pending
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        dec_eff_o = dec_req_i & (cnt_q != '0);
        unf_o     = dec_req_i & (cnt_q == '0);
        // A full counter may still take an increment if a retire to the same
        // register lands in the same cycle; only a lone increment saturates.
        ovf_o     = inc_i & ~dec_eff_o & (cnt_q == MAX_C);
        inc_eff_o = inc_i & ~ovf_o;
        cnt_d     = cnt_q;
        if (inc_eff_o && !dec_eff_o)
            cnt_d = cnt_q + CNT_W'(1);
        else if (dec_eff_o && !inc_eff_o)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module reg_scoreboard #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int CNT_W    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              src1_used,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic              src2_used,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic              retire_valid,
    input  logic [ADDR_W-1:0] retire_dest,
    output logic              stall,
    output logic              issue_accept,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W+1:0]  inflight,
    output logic              err_underflow,
    output logic              err_overflow
);
    localparam int          IF_W  = CNT_W + 2;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0] inc, ret_hit, inc_eff, dec_eff, ovf, unf;

    // ---------------- per-register counters ----------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign inc[i]     = issue_accept & issue_we & (issue_dest == ADDR_W'(i));
        assign ret_hit[i] = retire_valid & (retire_dest == ADDR_W'(i));
        assign pending[i] = |cnt[i];

        reg_sb_cnt #(
            .CNT_W    (CNT_W),
            .MAX_PEND (MAX_PEND)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc_i     (inc[i]),
            .dec_req_i (ret_hit[i]),
            .cnt_o     (cnt[i]),
            .inc_eff_o (inc_eff[i]),
            .dec_eff_o (dec_eff[i]),
            .ovf_o     (ovf[i]),
            .unf_o     (unf[i])
        );
    end

    // ---------------- hazard detection ----------------
    logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt;
    logic             src1_byp, src2_byp, src1_haz, src2_haz, struct_haz;

    assign src1_cnt = cnt[src1_addr];
    assign src2_cnt = cnt[src2_addr];
    assign dest_cnt = cnt[issue_dest];

    // The register file forwards WB data in the same cycle. That covers the
    // source only when this retire is the last outstanding write to it.
    assign src1_byp = retire_valid & (retire_dest == src1_addr) & (src1_cnt == ONE_C);
    assign src2_byp = retire_valid & (retire_dest == src2_addr) & (src2_cnt == ONE_C);

    assign src1_haz = src1_used & (src1_cnt != '0) & ~src1_byp;
    assign src2_haz = src2_used & (src2_cnt != '0) & ~src2_byp;

    // A full destination frees a slot if WB retires into it this cycle.
    assign struct_haz = issue_we & (dest_cnt == MAX_C) &
                        ~(retire_valid & (retire_dest == issue_dest));

    assign stall        = issue_valid & (src1_haz | src2_haz | struct_haz);
    assign issue_accept = issue_valid & ~stall;

    // ---------------- totals and error flags ----------------
    logic [IF_W-1:0] inflight_q, inflight_d;
    logic            unf_q, ovf_q;

    // At most one increment and one decrement can occur per cycle. Using the
    // applied events keeps inflight equal to the sum of the counters.
    assign inflight_d = inflight_q + IF_W'(|inc_eff) - IF_W'(|dec_eff);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            inflight_q <= '0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            unf_q      <= unf_q | (|unf);
            ovf_q      <= ovf_q | (|ovf);
        end
    end

    assign inflight      = inflight_q;
    assign err_underflow = unf_q;
    assign err_overflow  = ovf_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios plus a randomized run,
// every cycle compared against a counter-per-register reference model.
module tb_reg_scoreboard;
    localparam int NR = 4, AW = 2, CW = 2, MP = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid, issue_we, src1_used, src2_used, retire_valid;
    logic [AW-1:0] issue_dest, src1_addr, src2_addr, retire_dest;
    logic          stall, issue_accept, err_underflow, err_overflow;
    logic [NR-1:0] pending;
    logic [CW+1:0] inflight;

    reg_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW), .MAX_PEND(MP)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
        .src1_used(src1_used), .src1_addr(src1_addr),
        .src2_used(src2_used), .src2_addr(src2_addr),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .stall(stall), .issue_accept(issue_accept), .pending(pending),
        .inflight(inflight), .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_cnt[NR];
    bit m_unf, m_ovf;
    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_unf = 0;
        m_ovf = 0;
    endtask

    // Source value unavailable: a write is outstanding, unless WB delivers the
    // final one right now.
    function automatic bit m_src_wait(bit used, int a);
        return used && m_cnt[a] != 0 &&
               !(retire_valid && int'(retire_dest) == a && m_cnt[a] == 1);
    endfunction

    function automatic bit m_stall();
        if (!issue_valid) return 0;
        return m_src_wait(src1_used, int'(src1_addr)) ||
               m_src_wait(src2_used, int'(src2_addr)) ||
               (issue_we && m_cnt[issue_dest] == MP &&
                !(retire_valid && retire_dest == issue_dest));
    endfunction

    function automatic logic [NR-1:0] m_pending();
        logic [NR-1:0] p;
        for (int i = 0; i < NR; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < NR; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic m_clock();
        bit acc;
        acc = issue_valid && !m_stall();
        if (retire_valid) begin
            if (m_cnt[retire_dest] == 0) m_unf = 1;
            else m_cnt[retire_dest]--;
        end
        if (acc && issue_we) begin
            if (m_cnt[issue_dest] == MP) m_ovf = 1;
            else m_cnt[issue_dest]++;
        end
    endtask

    // Inputs are driven just after a negedge; check combinational outputs,
    // clock, then check registered state.
    task automatic cycle();
        bit s;
        #1;
        s = m_stall();
        chk("stall", stall, s);
        chk("issue_accept", issue_accept, issue_valid && !s);
        @(posedge clk);
        m_clock();
        #1;
        chk("pending", pending, m_pending());
        chk("inflight", inflight, m_sum());
        chk("err_underflow", err_underflow, m_unf);
        chk("err_overflow", err_overflow, m_ovf);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit we, input int d,
                         input bit u1, input int a1, input bit u2, input int a2,
                         input bit rv, input int rd);
        issue_valid  = v;
        issue_we     = we;
        issue_dest   = AW'(d);
        src1_used    = u1;
        src1_addr    = AW'(a1);
        src2_used    = u2;
        src2_addr    = AW'(a2);
        retire_valid = rv;
        retire_dest  = AW'(rd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        m_reset();
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        // Reset values, with a read request present that must not stall.
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_stall", stall, 0);
        chk("rst_unf", err_underflow, 0);
        chk("rst_ovf", err_overflow, 0);
        idle();
        reset_n = 1'b0;
        @(negedge clk);

        // First write to r2.
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("first_pending", pending, 4'b0100);
        chk("first_inflight", inflight, 1);

        // RAW on r2, no retire: stall.
        drive(1, 0, 0, 1, 2, 0, 0, 0, 0);
        #1;
        chk("raw_stall", stall, 1);
        chk("raw_accept", issue_accept, 0);
        cycle();
        // Same read with WB retiring r2: bypass.
        drive(1, 0, 0, 1, 2, 0, 0, 1, 2);
        #1;
        chk("byp_stall", stall, 0);
        cycle();
        chk("byp_pending", pending, 4'b0000);

        // Depth limit on r1.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        chk("depth_inflight", inflight, 3);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("depth_stall", stall, 1);
        cycle();
        drive(1, 1, 1, 0, 0, 0, 0, 1, 1);
        #1;
        chk("depth_ret_stall", stall, 0);
        cycle();
        chk("depth_keep", inflight, 3);

        // Simultaneous issue/retire on r3, then split across r0/r3.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 1, 3, 0, 0, 0, 0, 1, 3);
        cycle();
        chk("same_inflight", inflight, 5);
        drive(1, 1, 0, 0, 0, 0, 0, 1, 3);
        cycle();
        chk("split_pending", pending, 4'b1011);
        chk("split_inflight", inflight, 5);

        // Underflow: retire r2 which has nothing pending.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        cycle();
        chk("unf_set", err_underflow, 1);
        chk("unf_inflight", inflight, 5);
        idle();
        cycle();
        chk("unf_sticky", err_underflow, 1);

        // Asynchronous reset in mid-cycle.
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        #1;
        chk("pre_rst_stall", stall, 1);
        #2;
        reset_n = 1'b1;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_inflight", inflight, 0);
        chk("arst_stall", stall, 0);
        chk("arst_unf", err_underflow, 0);
        chk("arst_ovf", err_overflow, 0);
        m_reset();
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        @(negedge clk);

        // Randomized traffic; retires mostly target registers with work pending.
        for (int n = 0; n < 600; n++) begin
            int busy[$];
            int rd;
            bit rv;
            for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) busy.push_back(i);
            rv = ($urandom_range(99) < 45);
            if (busy.size() != 0 && $urandom_range(99) < 97)
                rd = busy[$urandom_range(busy.size() - 1)];
            else
                rd = $urandom_range(NR - 1);
            if (busy.size() == 0 && $urandom_range(99) < 90) rv = 0;
            drive($urandom_range(99) < 75, $urandom_range(99) < 70, $urandom_range(NR - 1),
                  $urandom_range(1), $urandom_range(NR - 1),
                  $urandom_range(1), $urandom_range(NR - 1),
                  rv, rd);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
